// File: rtl/gate_resp_checker_pkg.sv
// -----------------------------------------------------------------------------
// gate_chk_pkg
//   Shared definitions for the gate response checker:
//     - state_e     : checker FSM state encoding
//     - TT_*        : expected truth tables for common 2-input gates
//                     (bit i = expected output for input vector i)
//     - cnt_width() : bits needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    // Minimum of one bit so a zero settle time still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/gate_resp_checker_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
//   Loadable down-counter used to hold off sampling while the gates under
//   test settle. Loads LOAD on load_i, counts down by one per cycle while
//   dec_i is high, and stops at zero.
//
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   synchronous reset, active-high (counter -> 0)
//     load_i  in   load the counter with LOAD (has priority over dec_i)
//     dec_i   in   decrement enable
//     zero_o  out  counter currently equals zero
// -----------------------------------------------------------------------------
module settle_timer #(
    parameter int W    = 1,
    parameter int LOAD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam logic [W-1:0] LOAD_V = W'(LOAD);
    localparam logic [W-1:0] ONE_V  = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_V;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE_V;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its input from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_resp_checker.sv
// -----------------------------------------------------------------------------
// gate_resp_checker
//   Sequential response checker for a pair of small combinational gates.
//   Sweeps every input vector 0 .. 2^N_IN-1 onto stim, waits SETTLE idle
//   cycles, then samples both implementations (resp_a, resp_b) and compares
//   them with the expected truth table EXP_TT. Reports the mismatch count,
//   the first failing vector and a pass flag for the last completed sweep.
//
//   Parameters:
//     N_IN    number of gate inputs
//     SETTLE  idle cycles between driving a vector and sampling (0 allowed)
//     EXP_TT  expected truth table, bit i = expected output for vector i
//
//   Ports:
//     clk              in   clock, rising edge
//     rst              in   synchronous reset, active-high
//     start            in   single-cycle sweep request (ignored while busy)
//     stim             out  vector driven to both gates
//     resp_a           in   output of implementation A
//     resp_b           in   output of implementation B
//     busy             out  sweep in progress (state != IDLE)
//     done             out  one-cycle pulse at the end of a sweep
//     pass             out  last completed sweep had zero mismatches
//     err_count        out  mismatching vectors in the current/last sweep
//     first_err_vec    out  first vector that mismatched
//     first_err_valid  out  first_err_vec holds a valid vector
//
//   Build option:
//     GATE_CHK_STOP_ON_ERR_EN  when defined, the first mismatch ends the
//                              sweep immediately (stim stays on the failing
//                              vector, err_count = 1, pass = 0).
// -----------------------------------------------------------------------------
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]  EXP_TT = TT_AND
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            resp_a,
    input  logic            resp_b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int              CNT_W    = cnt_width(SETTLE);
    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fev_q, fev_d;
    logic            fevld_q, fevld_d;
    logic            pass_q, pass_d;

    logic tmr_load;
    logic tmr_zero;
    logic exp_bit;
    logic mismatch;

    settle_timer #(
        .W    (CNT_W),
        .LOAD (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .dec_i  (state_q == ST_SETTLE),
        .zero_o (tmr_zero)
    );

    // Case inequality makes an X or Z response count as a failure instead of
    // silently comparing equal.
    assign exp_bit  = EXP_TT[stim_q];
    assign mismatch = (resp_a !== exp_bit) || (resp_b !== exp_bit);

    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fevld_d  = fevld_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Results of the previous sweep are held until a new start.
                if (start) begin
                    stim_d   = '0;
                    err_d    = '0;
                    fevld_d  = 1'b0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                    if (!fevld_q) begin
                        fev_d   = stim_q;
                        fevld_d = 1'b1;
                    end
                end
`ifdef GATE_CHK_STOP_ON_ERR_EN
                if (mismatch || (stim_q == LAST_VEC)) begin
`else
                if (stim_q == LAST_VEC) begin
`endif
                    state_d = ST_DONE;
                end else begin
                    stim_d   = stim_q + VEC_ONE;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end

            ST_DONE: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevld_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevld_q <= fevld_d;
            pass_q  <= pass_d;
        end
    end

    assign stim            = stim_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevld_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_resp_checker
//   Two checker instances: u0 (defaults: SETTLE=1, AND table) and u1
//   (SETTLE=0, XOR table). The bench models the gates driving resp_a/resp_b,
//   queues hand-computed expected sweep results when it issues start, and a
//   monitor compares stim every busy cycle plus latency/err_count/first_err
//   at done and pass one cycle later.
// -----------------------------------------------------------------------------
module tb_gate_resp_checker;

    typedef enum int { M_GOOD, M_B_ONE, M_A_ZERO, M_A_ONE, M_AND } mode_e;

    typedef struct {
        int inst;
        int lat;
        int ec;
        int fv;
        bit fvv;
        bit pass;
        int fs;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [1:0]      start_w;
    logic [1:0][1:0] stim_w;
    logic [1:0]      ra_w, rb_w;
    logic [1:0]      busy_w, done_w, pass_w, fevld_w;
    logic [1:0][2:0] err_w;
    logic [1:0][1:0] fev_w;

    mode_e mode0, mode1;
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    gate_resp_checker u0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .stim(stim_w[0]),
        .resp_a(ra_w[0]), .resp_b(rb_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_count(err_w[0]), .first_err_vec(fev_w[0]),
        .first_err_valid(fevld_w[0])
    );

    gate_resp_checker #(.N_IN(2), .SETTLE(0), .EXP_TT(4'b0110)) u1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .stim(stim_w[1]),
        .resp_a(ra_w[1]), .resp_b(rb_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_count(err_w[1]), .first_err_vec(fev_w[1]),
        .first_err_valid(fevld_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Gate models: u0 expects AND, u1 expects XOR; faults replace outputs.
    always_comb begin
        ra_w[0] = stim_w[0][0] & stim_w[0][1];
        rb_w[0] = stim_w[0][0] & stim_w[0][1];
        case (mode0)
            M_B_ONE:  rb_w[0] = 1'b1;
            M_A_ZERO: ra_w[0] = 1'b0;
            M_A_ONE:  ra_w[0] = 1'b1;
            default:  ;
        endcase
        ra_w[1] = stim_w[1][0] ^ stim_w[1][1];
        rb_w[1] = stim_w[1][0] ^ stim_w[1][1];
        if (mode1 == M_AND) begin
            ra_w[1] = stim_w[1][0] & stim_w[1][1];
            rb_w[1] = stim_w[1][0] & stim_w[1][1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_sweep(input int inst, input int lat, input int ec, input int fv,
                                input bit fvv, input bit pass, input int fs);
        exp_t e;
        e.inst = inst; e.lat = lat; e.ec = ec; e.fv = fv;
        e.fvv = fvv; e.pass = pass; e.fs = fs;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start_w[i] = 1'b1;
        @(negedge clk);
        start_w[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (done_w[i] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout inst%0d: no done within 200 cycles", i);
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input int i, input string tag);
        check({tag, "_stim"},      stim_w[i],  0);
        check({tag, "_busy"},      busy_w[i],  0);
        check({tag, "_done"},      done_w[i],  0);
        check({tag, "_pass"},      pass_w[i],  0);
        check({tag, "_err_count"}, err_w[i],   0);
        check({tag, "_fev"},       fev_w[i],   0);
        check({tag, "_fevld"},     fevld_w[i], 0);
    endtask

    // Monitor: compares against the front of the scoreboard queue.
    int         t0[2];
    logic [1:0] bprev = '0;
    logic [1:0] pchk  = '0;
    exp_t       pend[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   k;
            int   ev;
            exp_t e;
            if (pchk[i]) begin
                check($sformatf("pass_inst%0d", i), pass_w[i], pend[i].pass);
                pchk[i] = 1'b0;
            end
            if (busy_w[i] === 1'b1 && bprev[i] !== 1'b1) t0[i] = cyc;
            if (busy_w[i] === 1'b1 && exp_q.size() > 0 && exp_q[0].inst == i) begin
                k  = cyc - t0[i];
                ev = k / ((i == 0) ? 3 : 2);
                if (ev > exp_q[0].fs) ev = exp_q[0].fs;
                check($sformatf("stim_inst%0d_k%0d", i, k), stim_w[i], ev);
            end
            if (done_w[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst%0d: got done, expected none", i);
                end else begin
                    e = exp_q.pop_front();
                    check("done_inst",     i,              e.inst);
                    check("done_latency",  cyc - t0[i] + 1, e.lat);
                    check("err_count",     err_w[i],       e.ec);
                    check("first_err_valid", fevld_w[i],   e.fvv);
                    if (e.fvv) check("first_err_vec", fev_w[i], e.fv);
                    pend[i] = e;
                    pchk[i] = 1'b1;
                end
            end
            bprev[i] = busy_w[i];
        end
    end

    initial begin
        bit found;
        rst     = 1'b1;
        start_w = '0;
        mode0   = M_GOOD;
        mode1   = M_GOOD;
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset_u0");
        check_zero(1, "reset_u1");
        @(negedge clk);
        rst = 1'b0;

        // Correct AND pair: 13-edge latency, pass.
        expect_sweep(0, 13, 0, 0, 0, 1, 3);
        pulse_start(0);
        wait_done(0);

        // resp_b stuck 1: mismatches at vectors 0,1,2.
`ifdef GATE_CHK_STOP_ON_ERR_EN
        expect_sweep(0, 4, 1, 0, 1, 0, 0);
`else
        expect_sweep(0, 13, 3, 0, 1, 0, 3);
`endif
        mode0 = M_B_ONE;
        pulse_start(0);
        wait_done(0);

        // resp_a stuck 0: only vector 3 mismatches.
        expect_sweep(0, 13, 1, 3, 1, 0, 3);
        mode0 = M_A_ZERO;
        pulse_start(0);
        wait_done(0);

        // resp_a stuck 1: vectors 0,1,2 mismatch.
`ifdef GATE_CHK_STOP_ON_ERR_EN
        expect_sweep(0, 4, 1, 0, 1, 0, 0);
`else
        expect_sweep(0, 13, 3, 0, 1, 0, 3);
`endif
        mode0 = M_A_ONE;
        pulse_start(0);
        wait_done(0);

        // Reset during vector-2 SETTLE: sweep abandoned, no done.
        mode0 = M_GOOD;
        pulse_start(0);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (stim_w[0] == 2'd2 && busy_w[0] === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        check("reached_vec2", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero(0, "midreset_u0");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean sweep after the abandoned one.
        expect_sweep(0, 13, 0, 0, 0, 1, 3);
        pulse_start(0);
        wait_done(0);

        // start while busy and in DONE ignored; start right after DONE accepted.
        expect_sweep(0, 13, 0, 0, 0, 1, 3);
        expect_sweep(0, 13, 0, 0, 0, 1, 3);
        pulse_start(0);
        repeat (4) @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) found = 1'b1;
        end
        check("first_done_seen", found, 1);
        start_w[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_w[0] = 1'b0;
        wait_done(0);

        // u1: SETTLE=0 with XOR gates, 9-edge latency.
        expect_sweep(1, 9, 0, 0, 0, 1, 3);
        pulse_start(1);
        wait_done(1);

        // u1 fed AND outputs against the XOR table: vectors 1,2,3 mismatch.
`ifdef GATE_CHK_STOP_ON_ERR_EN
        expect_sweep(1, 5, 1, 1, 1, 0, 1);
`else
        expect_sweep(1, 9, 3, 1, 1, 0, 3);
`endif
        mode1 = M_AND;
        pulse_start(1);
        wait_done(1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
